// File: rtl/nlc_horner_engine.sv
// ADC non-linearity correction: per-section normalisation u=(x-mean)*invstd, then Horner polynomial.
// Optional macro NLC_ROUND_EN: round half up on every >>>FRAC (default build truncates).
module nlc_horner_engine #(
  parameter  int unsigned XW    = 21,
  parameter  int unsigned CW    = 24,
  parameter  int unsigned FRAC  = 16,
  parameter  int unsigned NSEC  = 4,
  parameter  int unsigned ORDER = 6,
  parameter  int unsigned YW    = 32,
  localparam int unsigned AW    = $clog2(NSEC*(ORDER+3)+NSEC-1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic signed [XW-1:0] i_x,
  input  logic                 i_srdyi,
  output logic                 o_drdyi,
  output logic        [YW-1:0] o_y,
  output logic                 o_srdyo,
  output logic                 o_sat,
  input  logic                 i_cfg_we,
  input  logic        [AW-1:0] i_cfg_addr,
  input  logic signed [CW-1:0] i_cfg_data,
  output logic                 o_cfg_err
);

  localparam int unsigned ROW   = ORDER + 3;
  localparam int unsigned NCOEF = NSEC * ROW;
  localparam int unsigned TBL   = NCOEF + NSEC - 1;
  localparam int unsigned NB    = (NSEC > 1) ? NSEC - 1 : 1;
  localparam int unsigned SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int unsigned KW    = $clog2(ORDER + 1);
  localparam int unsigned DW    = XW + 1;
  localparam int unsigned MW    = (DW > CW) ? DW : CW;
  localparam int unsigned PM    = (DW + CW > 2 * CW) ? DW + CW : 2 * CW;
  localparam int unsigned PW    = PM + 2;
`ifdef NLC_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);
`endif

  typedef enum logic [1:0] {IDLE, CENTER, SCALE, HORNER} state_t;

  state_t               state_q, state_d;
  logic signed [CW-1:0] tbl   [NSEC][ROW];
  logic signed [CW-1:0] bnd   [NB];
  logic signed [CW-1:0] row_q [ROW];
  logic signed [XW-1:0] x_q;
  logic signed [DW-1:0] d_q, d_d;
  logic signed [CW-1:0] u_q, u_d, acc_q, acc_d, coef_k;
  logic        [KW-1:0] k_q, k_d;
  logic signed [YW-1:0] y_q, y_d;
  logic                 sat_q, sat_d, osat_q, osat_d, srdyo_q, srdyo_d;
  logic                 drdyi_q, cfg_err_q, accept, in_range;
  logic        [SW-1:0] sec_c;
  logic signed [MW-1:0] diff_w;
  logic signed [PW-1:0] prod_s, prod_h;
  logic        [CW:0]   u_r, acc_r;

  // Arithmetic shift by FRAC, optionally rounding half up.
  function automatic logic signed [PW-1:0] shr_frac(input logic signed [PW-1:0] p);
`ifdef NLC_ROUND_EN
    return (p + HALF) >>> FRAC;
`else
    return p >>> FRAC;
`endif
  endfunction

  // Clamp to signed CW bits; MSB of the result flags a clamp.
  function automatic logic [CW:0] sat_cw(input logic signed [PW-1:0] p);
    if ((&p[PW-1:CW-1]) || !(|p[PW-1:CW-1])) return {1'b0, p[CW-1:0]};
    return p[PW-1] ? {2'b11, {(CW-1){1'b0}}} : {2'b10, {(CW-1){1'b1}}};
  endfunction

  assign accept   = i_srdyi & drdyi_q;
  assign in_range = 32'(i_cfg_addr) < TBL;
  assign diff_w   = MW'(x_q) - MW'(row_q[ROW-2]);
  assign prod_s   = PW'(d_q) * PW'(row_q[ROW-1]);
  assign u_r      = sat_cw(shr_frac(prod_s));
  assign prod_h   = PW'(acc_q) * PW'(u_q);
  assign acc_r    = sat_cw(shr_frac(prod_h) + PW'(coef_k));

  // Section = number of boundaries at or below the incoming count.
  always_comb begin
    sec_c = '0;
    for (int j = 0; j < NSEC - 1; j++)
      if (MW'(i_x) >= MW'(bnd[j])) sec_c = sec_c + SW'(1);
  end

  always_comb begin
    coef_k = '0;
    for (int i = 0; i <= ORDER; i++)
      if (k_q == KW'(i)) coef_k = row_q[i];
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    u_d     = u_q;
    acc_d   = acc_q;
    k_d     = k_q;
    sat_d   = sat_q;
    y_d     = y_q;
    osat_d  = osat_q;
    srdyo_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CENTER;
          sat_d   = 1'b0;
        end
      end
      CENTER: begin
        d_d     = diff_w[DW-1:0];
        state_d = SCALE;
      end
      SCALE: begin
        u_d     = u_r[CW-1:0];
        sat_d   = sat_q | u_r[CW];
        acc_d   = row_q[ORDER];
        k_d     = KW'(ORDER - 1);
        state_d = HORNER;
      end
      HORNER: begin
        acc_d = acc_r[CW-1:0];
        sat_d = sat_q | acc_r[CW];
        k_d   = k_q - KW'(1);
        if (k_q == '0) begin
          y_d     = YW'($signed(acc_r[CW-1:0]));
          osat_d  = sat_q | acc_r[CW];
          srdyo_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      d_q       <= '0;
      u_q       <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      sat_q     <= 1'b0;
      y_q       <= '0;
      osat_q    <= 1'b0;
      srdyo_q   <= 1'b0;
      drdyi_q   <= 1'b1;
      cfg_err_q <= 1'b0;
      for (int s = 0; s < NSEC; s++)
        for (int i = 0; i < ROW; i++) tbl[s][i] <= '0;
      for (int j = 0; j < NB; j++) bnd[j] <= '0;
      for (int i = 0; i < ROW; i++) row_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      u_q       <= u_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      sat_q     <= sat_d;
      y_q       <= y_d;
      osat_q    <= osat_d;
      srdyo_q   <= srdyo_d;
      drdyi_q   <= (state_d == IDLE);
      cfg_err_q <= i_cfg_we & ~drdyi_q & in_range;
      // Snapshot the section row so a same-cycle table write cannot affect this sample.
      if (accept) begin
        x_q   <= i_x;
        row_q <= tbl[sec_c];
      end
      if (i_cfg_we && drdyi_q) begin
        for (int s = 0; s < NSEC; s++)
          for (int i = 0; i < ROW; i++)
            if (i_cfg_addr == AW'(s * ROW + i)) tbl[s][i] <= i_cfg_data;
        for (int j = 0; j < NSEC - 1; j++)
          if (i_cfg_addr == AW'(NCOEF + j)) bnd[j] <= i_cfg_data;
      end
    end
  end

  assign o_drdyi   = drdyi_q;
  assign o_y       = y_q;
  assign o_srdyo   = srdyo_q;
  assign o_sat     = osat_q;
  assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_nlc_horner_engine.sv
// Directed bench for nlc_horner_engine: vector table plus handshake, config and reset sequences.
module tb_nlc_horner_engine;

  localparam int XW = 21;
  localparam int CW = 24;
  localparam int YW = 32;
  localparam int AW = 6;
`ifdef NLC_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset, i_srdyi, i_cfg_we;
  logic [XW-1:0] i_x;
  logic [AW-1:0] i_cfg_addr;
  logic [CW-1:0] i_cfg_data;
  logic          o_drdyi, o_srdyo, o_sat, o_cfg_err;
  logic [YW-1:0] o_y;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  nlc_horner_engine dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_x(i_x), .i_srdyi(i_srdyi),
    .o_drdyi(o_drdyi), .o_y(o_y), .o_srdyo(o_srdyo), .o_sat(o_sat),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .o_cfg_err(o_cfg_err)
  );

  typedef struct {
    int     cfg;
    int     x;
    longint y;
    logic   sat;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    i_cfg_addr = AW'(addr);
    i_cfg_data = CW'(data);
    i_cfg_we   = 1'b1;
    @(posedge i_clk); #1;
    i_cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_srdyi  = 1'b0;
    i_cfg_we = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
  endtask

  task automatic program_cfg(input int cfg);
    case (cfg)
      1: for (int s = 0; s < 4; s++) begin wr(s*9 + 1, 65536); wr(s*9 + 8, 65536); end
      2: begin
        wr(36, -44978); wr(37, 0); wr(38, 44978);
        for (int s = 0; s < 4; s++) begin wr(s*9, 100*s); wr(s*9 + 8, 65536); end
      end
      3: for (int s = 0; s < 4; s++) begin wr(s*9 + 1, 65536); wr(s*9 + 8, 8323072); end
      default: for (int s = 0; s < 4; s++) begin wr(s*9 + 1, 32768); wr(s*9 + 8, 65536); end
    endcase
  endtask

  task automatic start(input int x, input string nm);
    int t = 0;
    while (!o_drdyi && t < 30) begin @(posedge i_clk); #1; t++; end
    chk({nm, " ready"}, longint'(o_drdyi), 1);
    i_x     = XW'(x);
    i_srdyi = 1'b1;
    @(posedge i_clk); #1;
    i_srdyi = 1'b0;
  endtask

  // c0 = edges already seen counting the accept edge as 1.
  task automatic finish(input longint ey, input logic es, input string nm, input int c0);
    int cyc = c0;
    while (!o_srdyo && cyc < 30) begin @(posedge i_clk); #1; cyc++; end
    chk({nm, " latency"}, cyc, 9);
    chk({nm, " y"}, longint'($signed(o_y)), ey);
    chk({nm, " sat"}, longint'(o_sat), longint'(es));
    @(posedge i_clk); #1;
    chk({nm, " pulse end"}, longint'(o_srdyo), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cur;
    int pulses;
    i_x = '0; i_cfg_addr = '0; i_cfg_data = '0;
    v[0]  = '{1, 1000, 1000, 1'b0};
    v[1]  = '{1, -7, -7, 1'b0};
    v[2]  = '{1, 1048575, 1048575, 1'b0};
    v[3]  = '{1, -1048576, -1048576, 1'b0};
    v[4]  = '{2, -50000, 0, 1'b0};
    v[5]  = '{2, -1, 100, 1'b0};
    v[6]  = '{2, 0, 200, 1'b0};
    v[7]  = '{2, 44978, 300, 1'b0};
    v[8]  = '{2, -44978, 100, 1'b0};
    v[9]  = '{2, 44977, 200, 1'b0};
    v[10] = '{3, 100000, 8388607, 1'b1};
    v[11] = '{3, 1, 127, 1'b0};
    v[12] = '{3, -100000, -8388608, 1'b1};
    v[13] = '{4, 3, 1 + RND, 1'b0};
    v[14] = '{4, -3, -2 + RND, 1'b0};

    do_reset();
    chk("reset drdyi", longint'(o_drdyi), 1);
    chk("reset srdyo", longint'(o_srdyo), 0);
    chk("reset y", longint'(o_y), 0);
    chk("reset sat", longint'(o_sat), 0);
    chk("reset cfg_err", longint'(o_cfg_err), 0);

    cur = 0;
    for (int i = 0; i < 15; i++) begin
      if (v[i].cfg != cur) begin
        do_reset();
        program_cfg(v[i].cfg);
        cur = v[i].cfg;
      end
      start(v[i].x, $sformatf("vec%0d", i));
      finish(v[i].y, v[i].sat, $sformatf("vec%0d", i), 1);
    end

    // Continuous i_srdyi: one result every 9 cycles, ready only in the result cycle.
    do_reset();
    program_cfg(1);
    i_x = XW'(5);
    i_srdyi = 1'b1;
    @(posedge i_clk); #1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge i_clk); #1;
      chk($sformatf("b2b drdyi e%0d", e), longint'(o_drdyi), longint'(e % 9 == 8));
      chk($sformatf("b2b srdyo e%0d", e), longint'(o_srdyo), longint'(e % 9 == 8));
      if (e % 9 == 8) chk($sformatf("b2b y e%0d", e), longint'($signed(o_y)), 5);
    end
    i_srdyi = 1'b0;
    repeat (10) @(posedge i_clk);
    #1 chk("b2b drained", longint'(o_drdyi), 1);

    // Write while busy is dropped and flagged.
    start(1000, "cerr");
    @(posedge i_clk); #1;
    wr(3*9 + 1, 0);
    chk("cerr pulse", longint'(o_cfg_err), 1);
    @(posedge i_clk); #1;
    chk("cerr pulse end", longint'(o_cfg_err), 0);
    finish(1000, 1'b0, "cerr busy", 4);
    start(1000, "cerr after");
    finish(1000, 1'b0, "cerr after", 1);

    // Write coincident with accept: the sample sees the old coefficient.
    i_x = XW'(1000);
    i_srdyi = 1'b1;
    i_cfg_addr = AW'(3*9 + 1);
    i_cfg_data = CW'(131072);
    i_cfg_we = 1'b1;
    @(posedge i_clk); #1;
    i_srdyi = 1'b0;
    i_cfg_we = 1'b0;
    chk("coinc no err", longint'(o_cfg_err), 0);
    finish(1000, 1'b0, "coinc old", 1);
    start(1000, "coinc new");
    finish(2000, 1'b0, "coinc new", 1);

    // Reset during HORNER aborts the sample and clears the table.
    start(1000, "rst");
    repeat (4) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("rst drdyi", longint'(o_drdyi), 1);
    chk("rst srdyo", longint'(o_srdyo), 0);
    chk("rst y", longint'(o_y), 0);
    pulses = 0;
    repeat (12) begin
      @(posedge i_clk); #1;
      if (o_srdyo) pulses++;
    end
    chk("rst no result", pulses, 0);
    start(500, "rst zero");
    finish(0, 1'b0, "rst zero", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
